// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch front-end
//
// Purpose: fetch FSM state encoding, the queue entry layout (PC tagged
// instruction) and the default program-end address.
// Ports: none (package).
package fetch_pkg;

  localparam int DATA_W = 20;
  localparam int ADDR_W = 8;
  localparam logic [ADDR_W-1:0] HALT_ADDR_DEFAULT = 8'hFA;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    STALL = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instruction;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - circular buffer of PC-tagged instructions
//
// Purpose: DEPTH-entry queue with wrap-around pointers; count decides
// full/empty. Flush empties the queue by moving rd_ptr onto wr_ptr and
// overrides any push or pop in the same cycle.
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   push      write wdata at the tail (ignored when full)
//   pop       drop the head entry (ignored when empty)
//   flush     discard all entries
//   wdata     entry to write
//   head      entry at rd_ptr (combinational)
//   count     current occupancy
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output fetch_entry_t head,
  output logic [CW-1:0] count
);

  fetch_entry_t mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic do_push;
  logic do_pop;

  assign do_push = push && (count != CW'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      // Storage is left as is; only the read side jumps to the write side.
      count  <= '0;
      rd_ptr <= wr_ptr;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_queue_unit.sv
// rtl/fetch_queue_unit.sv - instruction fetch front-end with PC-tagged queue
//
// Purpose: issues reads to a synchronous instruction memory, queues the
// returned instructions with their PCs and presents the head to ID through
// a valid/ready handshake. Redirects flush and restart fetch; fetch stops
// at HALT_ADDR.
// Ports:
//   clk, rst        clock and asynchronous active-high reset
//   imem_req/addr   memory read request and address
//   imem_data       read data, one cycle after the request
//   redirect/_pc    taken branch or jump from ID and its target
//   id_valid/ready  head handshake with ID
//   id_instruction  head instruction
//   id_pc           head PC
//   count           queue occupancy
//   halted          fetch done and queue drained (registered)
module fetch_queue_unit
  import fetch_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W,
  parameter int ADDRESS_WIDTH = ADDR_W,
  parameter int DEPTH = 4,
  parameter logic [ADDRESS_WIDTH-1:0] HALT_ADDR = HALT_ADDR_DEFAULT,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0]    imem_data,
  input  logic                     redirect,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
  output logic                     id_valid,
  input  logic                     id_ready,
  output logic [DATA_WIDTH-1:0]    id_instruction,
  output logic [ADDRESS_WIDTH-1:0] id_pc,
  output logic [CW-1:0]            count,
  output logic                     halted
);

  fetch_state_t             state;
  logic [ADDRESS_WIDTH-1:0] fetch_pc;
  logic [ADDRESS_WIDTH-1:0] req_pc;
  logic                     inflight;
  logic                     discard;
  logic [CW:0]              used;
  logic                     credit;
  logic [ADDRESS_WIDTH:0]   next_pc;
  logic                     next_at_halt;
  logic                     push;
  logic                     pop;
  fetch_entry_t             wdata;
  fetch_entry_t             head;

  // The in-flight request already owns a slot; a same-cycle dequeue only
  // frees credit once count has actually dropped.
  assign used         = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign credit       = used < (CW + 1)'(DEPTH);
  assign next_pc      = {1'b0, fetch_pc} + (ADDRESS_WIDTH + 1)'(1);
  assign next_at_halt = next_pc >= {1'b0, HALT_ADDR};

  // Gated by rst so the request line is quiet while reset is held.
  assign imem_req  = !rst && (state == FETCH) && credit;
  assign imem_addr = fetch_pc;

  assign push  = inflight && !discard && !redirect;
  assign pop   = id_valid && id_ready && !redirect;
  assign wdata = '{pc: req_pc, instruction: imem_data};

  assign id_valid       = (count != '0);
  assign id_instruction = head.instruction;
  assign id_pc          = head.pc;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .wdata (wdata),
    .head  (head),
    .count (count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FETCH;
      fetch_pc <= '0;
      req_pc   <= '0;
      inflight <= 1'b0;
      discard  <= 1'b0;
      halted   <= 1'b0;
    end else begin
      inflight <= imem_req;
      if (imem_req) req_pc <= fetch_pc;
      halted <= (state == HALT) && (count == '0) && !inflight;

      if (redirect) begin
        // The response arriving now is cancelled by the flush; a request
        // issued this cycle still returns next cycle and must be dropped.
        discard <= imem_req;
        if (redirect_pc >= HALT_ADDR) begin
          fetch_pc <= HALT_ADDR;
          state    <= HALT;
        end else begin
          fetch_pc <= redirect_pc;
          state    <= FETCH;
        end
      end else begin
        discard <= 1'b0;
        case (state)
          FETCH: begin
            if (credit) begin
              if (next_at_halt) begin
                fetch_pc <= HALT_ADDR;
                state    <= HALT;
              end else begin
                fetch_pc <= next_pc[ADDRESS_WIDTH-1:0];
              end
            end else begin
              state <= STALL;
            end
          end
          STALL: if (credit) state <= FETCH;
          HALT: fetch_pc <= HALT_ADDR;
          default: state <= FETCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb/tb_fetch_queue_unit.sv - self-checking bench for fetch_queue_unit
module tb_fetch_queue_unit;
  import fetch_pkg::*;

  localparam int DEPTH = 4;
  localparam logic [7:0] HALT = 8'hFA;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [19:0] imem_data = '0;
  logic        redirect = 1'b0;
  logic [7:0]  redirect_pc = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [19:0] id_instruction;
  logic [7:0]  id_pc;
  logic [2:0]  count;
  logic        halted;

  fetch_queue_unit #(
    .DATA_WIDTH(20), .ADDRESS_WIDTH(8), .DEPTH(DEPTH), .HALT_ADDR(HALT)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_instruction(id_instruction), .id_pc(id_pc),
    .count(count), .halted(halted)
  );

  always #5 clk = ~clk;

  // Synchronous-read instruction memory: word at addr is 20'h1000 + addr.
  always @(posedge clk) imem_data <= imem_req ? 20'h01000 + {12'h0, imem_addr} : 20'h0;

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: the queue as a list of PCs, one outstanding response slot, and
  // the next PC fetch must ask for.
  logic [7:0] mq_pc[$];
  int         dlog[$];
  bit         pend = 1'b0;
  bit         pend_dead = 1'b0;
  logic [7:0] pend_pc = '0;
  logic [7:0] exp_pc = '0;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_req", imem_req, 1'b0);
      chk("rst_valid", id_valid, 1'b0);
      chk("rst_halted", halted, 1'b0);
      chk("rst_count", count, 3'd0);
      mq_pc.delete();
      pend = 1'b0;
      pend_dead = 1'b0;
      exp_pc = '0;
    end else begin
      chk("valid", id_valid, mq_pc.size() != 0);
      chk("count", count, mq_pc.size());
      if (mq_pc.size() != 0) begin
        chk("head_pc", id_pc, mq_pc[0]);
        chk("head_instr", id_instruction, 20'h01000 + {12'h0, mq_pc[0]});
      end
      if (imem_req) begin
        chk("req_addr", imem_addr, exp_pc);
        chk("req_credit", (mq_pc.size() + int'(pend)) < DEPTH, 1'b1);
        chk("req_below_halt", imem_addr < HALT, 1'b1);
      end
      if (redirect) begin
        mq_pc.delete();
        pend = imem_req;
        pend_dead = 1'b1;
        pend_pc = exp_pc;
        exp_pc = (redirect_pc >= HALT) ? HALT : redirect_pc;
      end else begin
        if (id_valid && id_ready && mq_pc.size() != 0) begin
          dlog.push_back(int'(mq_pc[0]));
          void'(mq_pc.pop_front());
        end
        if (pend && !pend_dead) mq_pc.push_back(pend_pc);
        pend = imem_req;
        pend_dead = 1'b0;
        if (imem_req) begin
          pend_pc = exp_pc;
          exp_pc = exp_pc + 8'd1;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int n;
    int n0;
    bit ok;
    logic [7:0] p;

    step(3);
    rst = 1'b0;
    #1;
    chk("first_req", imem_req, 1'b1);
    chk("first_addr", imem_addr, 8'h00);
    id_ready = 1'b1;
    step(2);
    chk("first_valid", id_valid, 1'b1);
    chk("first_pc", id_pc, 8'h00);
    chk("first_instr", id_instruction, 20'h01000);
    step(15);
    ok = 1'b1;
    foreach (dlog[i]) if (dlog[i] != i) ok = 1'b0;
    chk("stream_order", ok, 1'b1);
    chk("stream_len", dlog.size(), 15);

    // Backpressure: four credits then no more requests.
    id_ready = 1'b0;
    step(10);
    chk("stall_count", count, 3'd4);
    chk("stall_req", imem_req, 1'b0);
    id_ready = 1'b1;
    step(10);
    ok = 1'b1;
    foreach (dlog[i]) if (dlog[i] != i) ok = 1'b0;
    chk("resume_order", ok, 1'b1);
    chk("resume_len", dlog.size() > 22, 1'b1);

    // Redirect with count=3 and a response in flight.
    id_ready = 1'b0;
    n = 0;
    while (count != 3'd3 && n < 20) begin step(1); n++; end
    chk("reach_cnt3", count, 3'd3);
    redirect = 1'b1;
    redirect_pc = 8'h40;
    step(1);
    redirect = 1'b0;
    chk("redir_valid", id_valid, 1'b0);
    chk("redir_req", imem_req, 1'b1);
    chk("redir_addr", imem_addr, 8'h40);
    id_ready = 1'b1;
    step(2);
    chk("redir_head_valid", id_valid, 1'b1);
    chk("redir_head_pc", id_pc, 8'h40);
    chk("redir_head_instr", id_instruction, 20'h01040);
    step(5);

    // Redirect and dequeue together with count=1.
    n = 0;
    while (count != 3'd1 && n < 20) begin step(1); n++; end
    chk("reach_cnt1", count, 3'd1);
    p = id_pc;
    redirect = 1'b1;
    redirect_pc = 8'h10;
    step(1);
    redirect = 1'b0;
    chk("rd_count", count, 3'd0);
    chk("rd_valid", id_valid, 1'b0);
    n0 = dlog.size();
    step(3);
    chk("rd_len", dlog.size() > n0, 1'b1);
    if (dlog.size() > n0) chk("rd_first", dlog[n0], 8'h10);
    chk("rd_no_dup", dlog[n0-1], int'(p) - 1);

    // Run to the program end and halt.
    redirect = 1'b1;
    redirect_pc = 8'hF0;
    step(1);
    redirect = 1'b0;
    n = 0;
    while (!halted && n < 40) begin step(1); n++; end
    chk("halt_reached", halted, 1'b1);
    chk("halt_last_pc", dlog[dlog.size()-1], 8'hF9);
    chk("halt_count", count, 3'd0);
    chk("halt_req", imem_req, 1'b0);
    redirect = 1'b1;
    redirect_pc = 8'hFF;
    step(1);
    redirect = 1'b0;
    step(2);
    chk("halt_stay", halted, 1'b1);
    chk("halt_noreq", imem_req, 1'b0);
    redirect = 1'b1;
    redirect_pc = 8'h20;
    step(1);
    redirect = 1'b0;
    chk("unhalt_req", imem_req, 1'b1);
    chk("unhalt_addr", imem_addr, 8'h20);
    step(1);
    chk("unhalt_halted", halted, 1'b0);

    // Asynchronous reset mid-burst.
    step(3);
    id_ready = 1'b0;
    n = 0;
    while (count != 3'd2 && n < 20) begin step(1); n++; end
    chk("reach_cnt2", count, 3'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_req", imem_req, 1'b0);
    chk("arst_addr", imem_addr, 8'h00);
    chk("arst_valid", id_valid, 1'b0);
    chk("arst_count", count, 3'd0);
    chk("arst_pc", id_pc, 8'h00);
    chk("arst_instr", id_instruction, 20'h0);
    chk("arst_halted", halted, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("restart_req", imem_req, 1'b1);
    chk("restart_addr", imem_addr, 8'h00);
    id_ready = 1'b1;
    step(2);
    chk("restart_valid", id_valid, 1'b1);
    chk("restart_pc", id_pc, 8'h00);
    step(3);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
